// File: rtl/operand_fetch.sv
// operand_fetch: decode/operand-fetch stage of the RV32 core.
// Pulls rs1/rs2/rd out of the incoming instruction and drives the regfile read ports.
// Resolves each operand with EX and WB forwarding. Stalls one cycle on a load-use
// hazard. Registers the result into a valid/ready pipeline register for execute.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      handshake with fetch
//   in_pc, in_instr        incoming PC and instruction
//   ra1, ra2 / rd1, rd2    regfile read addresses (comb) and read data (pre-write)
//   ex_we/ex_is_load/ex_wa/ex_wd   producer currently in EX
//   wb_we/wb_wa/wb_wd      regfile write port this cycle
//   flush                  kill the instruction in this stage
//   out_valid/out_ready    handshake with execute
//   out_pc/out_instr/out_op1/out_op2/out_rd   registered payload
module operand_fetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_instr,
  output logic [ADDR_WIDTH-1:0] ra1,
  output logic [ADDR_WIDTH-1:0] ra2,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] rd2,
  input  logic                  ex_we,
  input  logic                  ex_is_load,
  input  logic [ADDR_WIDTH-1:0] ex_wa,
  input  logic [DATA_WIDTH-1:0] ex_wd,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_wa,
  input  logic [DATA_WIDTH-1:0] wb_wd,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [ADDR_WIDTH-1:0] out_rd
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [6:0]            opcode;
  logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic                  uses_rs1, uses_rs2;
  logic                  stall;
  logic [DATA_WIDTH-1:0] op1, op2;

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] pc_q, instr_q, op1_q, op2_q;
  logic [ADDR_WIDTH-1:0] rd_q;

  assign opcode = in_instr[6:0];
  assign rs1    = ADDR_WIDTH'(in_instr[19:15]);
  assign rs2    = ADDR_WIDTH'(in_instr[24:20]);
  assign ra1    = rs1;
  assign ra2    = rs2;

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    rd       = ADDR_WIDTH'(in_instr[11:7]);
    case (opcode)
      OpLui, OpAuipc, OpJal: uses_rs1 = 1'b0;
      OpReg:                 uses_rs2 = 1'b1;
      OpStore, OpBranch: begin
        uses_rs2 = 1'b1;
        rd       = '0;
      end
      default: ;
    endcase
  end

  // Loads in EX cannot forward: their data only exists once they reach WB.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [ADDR_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  e_we,
    input logic                  e_load,
    input logic [ADDR_WIDTH-1:0] e_wa,
    input logic [DATA_WIDTH-1:0] e_wd,
    input logic                  w_we,
    input logic [ADDR_WIDTH-1:0] w_wa,
    input logic [DATA_WIDTH-1:0] w_wd
  );
    if (src == '0)                          return '0;
    else if (e_we && e_wa == src && !e_load) return e_wd;
    else if (w_we && w_wa == src)            return w_wd;  // regfile still returns old value
    else                                     return rf_data;
  endfunction

  assign op1 = resolve(rs1, rd1, ex_we, ex_is_load, ex_wa, ex_wd, wb_we, wb_wa, wb_wd);
  assign op2 = resolve(rs2, rd2, ex_we, ex_is_load, ex_wa, ex_wd, wb_we, wb_wa, wb_wd);

  assign stall = in_valid && ex_we && ex_is_load && (ex_wa != '0) &&
                 ((uses_rs1 && ex_wa == rs1) || (uses_rs2 && ex_wa == rs2));

  assign in_ready = !stall && (!valid_q || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      pc_q    <= in_pc;
      instr_q <= in_instr;
      op1_q   <= op1;
      op2_q   <= op2;
      rd_q    <= rd;
    end else if (out_ready) begin
      // Consumed with nothing new (stall bubble or idle fetch).
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by randomized traffic,
// all checked against a pipeline-register model fed by a bench-side register file.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_instr;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        ex_we, ex_is_load;
  logic [4:0]  ex_wa;
  logic [31:0] ex_wd;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, out_op1, out_op2;
  logic [4:0]  out_rd;

  operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_wd(ex_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bench register file and model of the output register.
  logic [31:0] regs [32];
  logic        m_valid;
  logic [31:0] m_pc, m_instr, m_op1, m_op2;
  logic [4:0]  m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_value(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (ex_we && !ex_is_load && ex_wa == idx) return ex_wd;
    if (wb_we && wb_wa == idx) return wb_wd;
    return regs[idx];
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] ins);
    if (ins[6:0] inside {7'b0100011, 7'b1100011}) return 5'd0;
    return ins[11:7];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_instr = 0; m_op1 = 0; m_op2 = 0; m_rd = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_instr = 0;
    ex_we = 0; ex_is_load = 0; ex_wa = 0; ex_wd = 0;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    flush = 0; out_ready = 1;
  endtask

  // Inputs are already set; check comb and registered outputs, then clock once.
  task automatic step();
    logic [4:0] s1, s2;
    logic       hazard, exp_ready;
    s1  = in_instr[19:15];
    s2  = in_instr[24:20];
    rd1 = regs[s1];
    rd2 = regs[s2];
    #1;
    hazard = in_valid && ex_we && ex_is_load && ex_wa != 0 &&
             ((reads_rs1(in_instr[6:0]) && ex_wa == s1) ||
              (reads_rs2(in_instr[6:0]) && ex_wa == s2));
    exp_ready = !hazard && (!m_valid || out_ready);
    chk("ra1", {27'b0, ra1}, {27'b0, s1});
    chk("ra2", {27'b0, ra2}, {27'b0, s2});
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (in_valid && exp_ready) begin
      m_valid = 1;
      m_pc    = in_pc;
      m_instr = in_instr;
      m_op1   = src_value(s1);
      m_op2   = src_value(s2);
      m_rd    = dest_of(in_instr);
    end else if (out_ready) m_valid = 0;
    if (wb_we && wb_wa != 0) regs[wb_wa] = wb_wd;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_pc", out_pc, m_pc);
    chk("out_instr", out_instr, m_instr);
    chk("out_op1", out_op1, m_op1);
    chk("out_op2", out_op2, m_op2);
    chk("out_rd", {27'b0, out_rd}, {27'b0, m_rd});
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic async_reset();
    rst_n = 0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_op1", out_op1, 32'h0);
    chk("rst_op2", out_op2, 32'h0);
    chk("rst_rd", {27'b0, out_rd}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
            7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011};
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
    idle_inputs();
    rd1 = 0; rd2 = 0;
    model_reset();
    rst_n = 0;
    #3;
    chk("init_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1;

    // Load something so the following reset hits a live instruction.
    in_valid = 1; in_pc = 32'h100; in_instr = 32'h002081B3;
    step();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    async_reset();

    // ADDI x1,x0,5 after reset release.
    idle_inputs();
    in_valid = 1; in_pc = 32'h200; in_instr = 32'h00500093;
    step();
    chk("addi_op1", out_op1, 32'h0);
    chk("addi_rd", {27'b0, out_rd}, 32'h1);
    chk("addi_valid", {31'b0, out_valid}, 32'h1);

    // EX forwarding on ADD x3,x1,x2.
    regs[1] = 32'h11;
    in_pc = 32'h204; in_instr = 32'h002081B3;
    ex_we = 1; ex_wa = 1; ex_wd = 32'hAA;
    step();
    chk("ex_fwd", out_op1, 32'hAA);

    // WB bypass, then EX over WB priority.
    regs[2] = 32'h0;
    ex_we = 0; wb_we = 1; wb_wa = 2; wb_wd = 32'hFFFF0000;
    step();
    chk("wb_bypass", out_op2, 32'hFFFF0000);
    regs[2] = 32'h0;
    ex_we = 1; ex_wa = 2; ex_wd = 32'h5;
    step();
    chk("ex_over_wb", out_op2, 32'h5);

    // Load-use: SW x5,0(x6) behind a load to x5.
    idle_inputs();
    in_valid = 1; in_pc = 32'h300; in_instr = 32'h00532023;
    ex_we = 1; ex_is_load = 1; ex_wa = 5; ex_wd = 32'h1234;
    step();
    chk("lu_bubble", {31'b0, out_valid}, 32'h0);
    ex_we = 0; ex_is_load = 0;
    wb_we = 1; wb_wa = 5; wb_wd = 32'hDEADBEEF;
    step();
    chk("lu_wb_value", out_op2, 32'hDEADBEEF);
    chk("lu_accept", {31'b0, out_valid}, 32'h1);
    // LUI x5 with rs1 field = x5: no stall.
    wb_we = 0;
    ex_we = 1; ex_is_load = 1; ex_wa = 5;
    in_pc = 32'h304; in_instr = 32'h000282B7;
    step();
    chk("lui_no_stall", {31'b0, out_valid}, 32'h1);

    // Backpressure for three cycles, then release.
    idle_inputs();
    in_valid = 1; in_pc = 32'h400; in_instr = 32'h00500093;
    step();
    out_ready = 0; in_pc = 32'h404; in_instr = 32'h00A00113;
    for (int k = 0; k < 3; k++) step();
    chk("bp_hold_pc", out_pc, 32'h400);
    out_ready = 1;
    step();
    chk("bp_next_pc", out_pc, 32'h404);

    // Flush with live output and incoming instruction.
    flush = 1; in_pc = 32'h500;
    step();
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    flush = 0;

    // Randomized traffic with occasional mid-run reset.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      if (i % 150 == 75) async_reset();
      ins        = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 7)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      in_instr   = ins;
      in_pc      = $urandom;
      in_valid   = ($urandom_range(0, 9) < 8);
      ex_we      = $urandom_range(0, 1);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_wa      = 5'($urandom_range(0, 7));
      ex_wd      = $urandom;
      wb_we      = $urandom_range(0, 1);
      wb_wa      = 5'($urandom_range(0, 7));
      wb_wd      = $urandom;
      flush      = ($urandom_range(0, 9) == 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch pipeline stage of the RV32 core. It sits between the fetch stage and execute. It extracts rs1/rs2/rd from the incoming instruction and drives the register file read ports. It resolves operands with forwarding from EX and WB, stalls one cycle on a load-use hazard, and registers the result into a valid/ready pipeline register feeding execute.

## Interface
- DATA_WIDTH, 32, operand/PC/instruction width
- ADDR_WIDTH, 5, register index width (32 registers)

Ports (clock and reset first):
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  DATA_WIDTH  PC of the incoming instruction
- in_instr  in  DATA_WIDTH  incoming instruction
- ra1, ra2  out  ADDR_WIDTH  regfile read addresses, combinational: in_instr[19:15] and in_instr[24:20]
- rd1, rd2  in  DATA_WIDTH  regfile read data, combinational, pre-write value
- ex_we, ex_is_load  in  1  instruction in EX writes a register / is a load
- ex_wa  in  ADDR_WIDTH  EX destination register
- ex_wd  in  DATA_WIDTH  EX ALU result
- wb_we  in  1  regfile write this cycle (same signal as the regfile `we`)
- wb_wa, wb_wd  in  ADDR_WIDTH / DATA_WIDTH  regfile write address/data
- flush  in  1  branch/jump redirect; kill the instruction in this stage
- out_valid  out  1  output register holds a live instruction
- out_ready  in  1  execute accepts the output this cycle
- out_pc, out_instr  out  DATA_WIDTH  registered PC and instruction
- out_op1, out_op2  out  DATA_WIDTH  registered resolved operands
- out_rd  out  ADDR_WIDTH  registered destination index; 0 if the instruction writes no register

## Operation
- Decode uses opcode in_instr[6:0]:
  - uses_rs1 = 0 for LUI (0110111), AUIPC (0010111) and JAL (1101111); 1 otherwise.
  - uses_rs2 = 1 only for R-type (0110011), STORE (0100011) and BRANCH (1100011).
  - out_rd = in_instr[11:7], forced to 0 for STORE and BRANCH.
- Operand resolution for each source s, in priority order:
  - index 0 → 0;
  - ex_we && ex_wa==s && !ex_is_load → ex_wd;
  - wb_we && wb_wa==s → wb_wd;
  - otherwise rd1/rd2.
- Unused sources still resolve by the same rule. Their value is don't-care downstream, but it must be deterministic.
- Load-use stall: stall = in_valid && ex_we && ex_is_load && ex_wa!=0 && ((uses_rs1 && ex_wa==rs1) || (uses_rs2 && ex_wa==rs2)).
- in_ready = !stall && (!out_valid || out_ready).
- Output register update, highest priority first:
  1. flush → out_valid<=0.
  2. in_valid && in_ready → load all out_* and set out_valid<=1.
  3. out_ready → out_valid<=0. This covers a stall bubble or no input.
  4. Otherwise hold all out_* unchanged.
- While out_valid && !out_ready, the out_* payload is stable.
- flush with in_valid the same cycle drops the incoming instruction. in_ready stays combinational; fetch discards it on flush.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_pc=0, out_instr=0, out_op1=0, out_op2=0, out_rd=0. Reset release is synchronous to clk.
- Reset mid-operation clears the held instruction immediately; no partial state survives.
- ra1/ra2/in_ready are combinational from inputs. No registered path from in_* to in_ready.
- Latency: one cycle. An instruction accepted at edge N appears on out_* after edge N.
- Load-use hazard costs exactly one bubble cycle. The next cycle EX holds the bubble, and the load result arrives via the WB path.
- WB bypass is required: the regfile returns the old value in the cycle of its own write.

## Test plan
- Reset: assert rst_n=0 mid-run with out_valid=1 → all outputs 0 before the next edge. After release, ADDI x1,x0,5 (00500093) accepted → out_op1=0, out_rd=1, out_valid=1 one cycle later.
- EX forwarding: ADD x3,x1,x2 with ex_we=1, ex_wa=1, ex_wd=32'h0000_00AA, regfile rd1=32'h11 → out_op1=32'hAA. With ex_wa=0 → out_op1=0 for rs1=x0.
- WB bypass and priority: rs2=x2, wb_we=1, wb_wa=2, wb_wd=32'hFFFF0000, rd2=0 → out_op2=32'hFFFF0000. Adding ex_wa=2, ex_wd=32'h5 → out_op2=32'h5.
- Load-use: ex_is_load=1, ex_we=1, ex_wa=5, incoming SW x5,0(x6) → in_ready=0 one cycle, out_valid=0 bubble. Next cycle the instruction is accepted with the WB value. LUI x5 under the same EX state → no stall.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles → in_ready=0 and out_* unchanged. On out_ready=1 the next instruction loads in the same edge.
- Flush: flush=1 while in_valid=1 and out_valid=1 → out_valid=0 next cycle, incoming instruction dropped.
